// File: rtl/lcd_pkg.sv
// rtl/lcd_pkg.sv - shared command codes, parser states and pixel width for the LCD SPI receiver
package lcd_pkg;

  localparam logic [7:0] CMD_CASET = 8'h2A;
  localparam logic [7:0] CMD_RASET = 8'h2B;
  localparam logic [7:0] CMD_RAMWR = 8'h2C;

  localparam int RGB565_W = 16;

  typedef enum logic [2:0] {
    IDLE,
    CASET,
    RASET,
    RAMWR_HI,
    RAMWR_LO
  } parser_state_e;

endpackage

// File: rtl/lcd_spi_rx_if.sv
// rtl/lcd_spi_rx_if.sv - 4-wire SPI LCD link pins (sclk, mosi, cs, dc, reset)
interface lcd_spi_rx_if;

  logic lcd_spi_sclk;
  logic lcd_spi_mosi;
  logic lcd_spi_cs;
  logic lcd_dc;
  logic lcd_reset;

  modport master (
    output lcd_spi_sclk, lcd_spi_mosi, lcd_spi_cs, lcd_dc, lcd_reset
  );

  modport slave (
    input lcd_spi_sclk, lcd_spi_mosi, lcd_spi_cs, lcd_dc, lcd_reset
  );

endinterface

// File: rtl/lcd_spi_deser.sv
// rtl/lcd_spi_deser.sv - pin synchroniser, sclk edge detect and byte deserialiser
module lcd_spi_deser #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sclk_i,
  input  logic       mosi_i,
  input  logic       cs_i,
  input  logic       dc_i,
  input  logic       lcd_reset_i,
  output logic [7:0] rx_byte,
  output logic       rx_dc,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       panel_rst
);

  // Bit order {lcd_reset, cs, dc, mosi, sclk}; reset/cs idle high so reset looks inactive
  localparam logic [4:0] SYNC_RST = 5'b11000;

  logic [4:0] sync_q [SYNC_STAGES];
  logic [4:0] pins_s;
  logic       sclk_s, mosi_s, dc_s, cs_s, reset_s, rise;

  logic       sclk_prev_q, sclk_prev_d;
  logic [7:0] shift_q, shift_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] rx_byte_q, rx_byte_d;
  logic       rx_dc_q, rx_dc_d;
  logic       rx_valid_q, rx_valid_d;
  logic       frame_err_q, frame_err_d;

  // Multi-stage synchroniser chain for every link pin
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= SYNC_RST;
    end else begin
      sync_q[0] <= {lcd_reset_i, cs_i, dc_i, mosi_i, sclk_i};
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign pins_s  = sync_q[SYNC_STAGES-1];
  assign sclk_s  = pins_s[0];
  assign mosi_s  = pins_s[1];
  assign dc_s    = pins_s[2];
  assign cs_s    = pins_s[3];
  assign reset_s = pins_s[4];
  assign rise    = sclk_s & ~sclk_prev_q;

  // Shift on sclk rise; panel reset beats cs, cs beats a completing byte
  always_comb begin
    sclk_prev_d = sclk_s;
    shift_d     = shift_q;
    bit_cnt_d   = bit_cnt_q;
    rx_byte_d   = rx_byte_q;
    rx_dc_d     = rx_dc_q;
    rx_valid_d  = 1'b0;
    frame_err_d = frame_err_q;
    if (!reset_s) begin
      bit_cnt_d = 3'd0;
    end else if (cs_s) begin
      bit_cnt_d = 3'd0;
      if (bit_cnt_q != 3'd0) frame_err_d = 1'b1;
    end else if (rise) begin
      shift_d   = {shift_q[6:0], mosi_s};
      bit_cnt_d = bit_cnt_q + 3'd1;
      if (bit_cnt_q == 3'd7) begin
        rx_byte_d  = shift_d;
        rx_dc_d    = dc_s;
        rx_valid_d = 1'b1;
      end
    end
  end

  // Deserialiser state register
  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_prev_q <= 1'b0;
      shift_q     <= 8'd0;
      bit_cnt_q   <= 3'd0;
      rx_byte_q   <= 8'd0;
      rx_dc_q     <= 1'b0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      sclk_prev_q <= sclk_prev_d;
      shift_q     <= shift_d;
      bit_cnt_q   <= bit_cnt_d;
      rx_byte_q   <= rx_byte_d;
      rx_dc_q     <= rx_dc_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign rx_byte   = rx_byte_q;
  assign rx_dc     = rx_dc_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;
  assign panel_rst = ~reset_s;

endmodule

// File: rtl/lcd_spi_rx.sv
// rtl/lcd_spi_rx.sv - LCD SPI receiver: command parser, address window and pixel stream
module lcd_spi_rx
  import lcd_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int COORD_W     = 16,
  parameter int X_MAX_DEF   = 239,
  parameter int Y_MAX_DEF   = 319
) (
  input  logic                clk,
  input  logic                rst,
  lcd_spi_rx_if.slave         spi,
  output logic [7:0]          rx_byte,
  output logic                rx_dc,
  output logic                rx_valid,
  output logic [COORD_W-1:0]  x_start,
  output logic [COORD_W-1:0]  x_end,
  output logic [COORD_W-1:0]  y_start,
  output logic [COORD_W-1:0]  y_end,
  output logic [RGB565_W-1:0] pix_data,
  output logic [COORD_W-1:0]  pix_x,
  output logic [COORD_W-1:0]  pix_y,
  output logic                pix_valid,
  output logic                frame_err,
  output logic [31:0]         byte_cnt
);

  localparam logic [COORD_W-1:0] X_END_RST = COORD_W'(X_MAX_DEF);
  localparam logic [COORD_W-1:0] Y_END_RST = COORD_W'(Y_MAX_DEF);

  logic panel_rst;

  lcd_spi_deser #(.SYNC_STAGES(SYNC_STAGES)) u_deser (
    .clk         (clk),
    .rst         (rst),
    .sclk_i      (spi.lcd_spi_sclk),
    .mosi_i      (spi.lcd_spi_mosi),
    .cs_i        (spi.lcd_spi_cs),
    .dc_i        (spi.lcd_dc),
    .lcd_reset_i (spi.lcd_reset),
    .rx_byte     (rx_byte),
    .rx_dc       (rx_dc),
    .rx_valid    (rx_valid),
    .frame_err   (frame_err),
    .panel_rst   (panel_rst)
  );

  parser_state_e       state_q, state_d;
  logic [1:0]          arg_idx_q, arg_idx_d;
  logic [23:0]         arg_q, arg_d;
  logic [COORD_W-1:0]  xs_q, xs_d, xe_q, xe_d, ys_q, ys_d, ye_q, ye_d;
  logic [7:0]          pix_hi_q, pix_hi_d;
  logic [RGB565_W-1:0] pix_data_q, pix_data_d;
  logic [COORD_W-1:0]  pix_x_q, pix_x_d, pix_y_q, pix_y_d;
  logic                pix_valid_q, pix_valid_d;
  logic [31:0]         byte_cnt_q, byte_cnt_d;

  // Parser next state, window capture and raster-order coordinate advance
  always_comb begin
    state_d     = state_q;
    arg_idx_d   = arg_idx_q;
    arg_d       = arg_q;
    xs_d        = xs_q;
    xe_d        = xe_q;
    ys_d        = ys_q;
    ye_d        = ye_q;
    pix_hi_d    = pix_hi_q;
    pix_data_d  = pix_data_q;
    pix_x_d     = pix_x_q;
    pix_y_d     = pix_y_q;
    pix_valid_d = 1'b0;
    byte_cnt_d  = byte_cnt_q + 32'(rx_valid);
    if (panel_rst) begin
      state_d    = IDLE;
      arg_idx_d  = 2'd0;
      arg_d      = 24'd0;
      xs_d       = '0;
      xe_d       = X_END_RST;
      ys_d       = '0;
      ye_d       = Y_END_RST;
      pix_hi_d   = 8'd0;
      pix_data_d = '0;
      pix_x_d    = '0;
      pix_y_d    = '0;
    end else begin
      if (pix_valid_q) begin
        if (pix_x_q == xe_q) begin
          pix_x_d = xs_q;
          pix_y_d = (pix_y_q == ye_q) ? ys_q : pix_y_q + COORD_W'(1);
        end else begin
          pix_x_d = pix_x_q + COORD_W'(1);
        end
      end
      if (rx_valid && !rx_dc) begin
        arg_idx_d = 2'd0;
        case (rx_byte)
          CMD_CASET: state_d = CASET;
          CMD_RASET: state_d = RASET;
          CMD_RAMWR: begin
            state_d = RAMWR_HI;
            pix_x_d = xs_q;
            pix_y_d = ys_q;
          end
          default:   state_d = IDLE;
        endcase
      end else if (rx_valid) begin
        case (state_q)
          CASET, RASET: begin
            if (arg_idx_q == 2'd3) begin
              state_d   = IDLE;
              arg_idx_d = 2'd0;
              if (state_q == CASET) begin
                xs_d = COORD_W'(arg_q[23:8]);
                xe_d = COORD_W'({arg_q[7:0], rx_byte});
              end else begin
                ys_d = COORD_W'(arg_q[23:8]);
                ye_d = COORD_W'({arg_q[7:0], rx_byte});
              end
            end else begin
              arg_idx_d = arg_idx_q + 2'd1;
              case (arg_idx_q)
                2'd0:    arg_d[23:16] = rx_byte;
                2'd1:    arg_d[15:8]  = rx_byte;
                default: arg_d[7:0]   = rx_byte;
              endcase
            end
          end
          RAMWR_HI: begin
            pix_hi_d = rx_byte;
            state_d  = RAMWR_LO;
          end
          RAMWR_LO: begin
            pix_data_d  = {pix_hi_q, rx_byte};
            pix_valid_d = 1'b1;
            state_d     = RAMWR_HI;
          end
          default: ;
        endcase
      end
    end
  end

  // Parser, window and pixel registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      arg_idx_q   <= 2'd0;
      arg_q       <= 24'd0;
      xs_q        <= '0;
      xe_q        <= X_END_RST;
      ys_q        <= '0;
      ye_q        <= Y_END_RST;
      pix_hi_q    <= 8'd0;
      pix_data_q  <= '0;
      pix_x_q     <= '0;
      pix_y_q     <= '0;
      pix_valid_q <= 1'b0;
      byte_cnt_q  <= 32'd0;
    end else begin
      state_q     <= state_d;
      arg_idx_q   <= arg_idx_d;
      arg_q       <= arg_d;
      xs_q        <= xs_d;
      xe_q        <= xe_d;
      ys_q        <= ys_d;
      ye_q        <= ye_d;
      pix_hi_q    <= pix_hi_d;
      pix_data_q  <= pix_data_d;
      pix_x_q     <= pix_x_d;
      pix_y_q     <= pix_y_d;
      pix_valid_q <= pix_valid_d;
      byte_cnt_q  <= byte_cnt_d;
    end
  end

  assign x_start   = xs_q;
  assign x_end     = xe_q;
  assign y_start   = ys_q;
  assign y_end     = ye_q;
  assign pix_data  = pix_data_q;
  assign pix_x     = pix_x_q;
  assign pix_y     = pix_y_q;
  assign pix_valid = pix_valid_q;
  assign byte_cnt  = byte_cnt_q;

endmodule

// File: tb/tb_lcd_spi_rx.sv
// tb/tb_lcd_spi_rx.sv - directed table-driven bench for lcd_spi_rx
module tb_lcd_spi_rx;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  rx_byte;
  logic        rx_dc, rx_valid, pix_valid, frame_err;
  logic [15:0] x_start, x_end, y_start, y_end, pix_data, pix_x, pix_y;
  logic [31:0] byte_cnt;

  lcd_spi_rx_if spi_if ();

  lcd_spi_rx dut (
    .clk (clk), .rst (rst), .spi (spi_if),
    .rx_byte (rx_byte), .rx_dc (rx_dc), .rx_valid (rx_valid),
    .x_start (x_start), .x_end (x_end), .y_start (y_start), .y_end (y_end),
    .pix_data (pix_data), .pix_x (pix_x), .pix_y (pix_y), .pix_valid (pix_valid),
    .frame_err (frame_err), .byte_cnt (byte_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          rx_n    = 0;
  int          rx_cyc  = 0;
  int          rise_cyc = 0;
  int          exp_bytes = 0;
  logic [7:0]  last_b;
  logic        last_dc;
  logic [15:0] pq_x[$], pq_y[$], pq_d[$];

  // Event monitor, sampled 3 ns after the active edge
  always begin
    @(posedge clk);
    #3;
    if (rx_valid) begin
      rx_n++;
      last_b  = rx_byte;
      last_dc = rx_dc;
      rx_cyc  = cyc;
    end
    if (pix_valid) begin
      pq_x.push_back(pix_x);
      pq_y.push_back(pix_y);
      pq_d.push_back(pix_data);
    end
  end

  typedef struct {
    logic        dc;
    logic [7:0]  data;
    logic [15:0] xs, xe, ys, ye;
    int          npix;
  } vec_t;

  vec_t vq[$];

  task automatic add_vec(input logic dc, input logic [7:0] d, input int xs, xe, ys, ye, np);
    vec_t v;
    v.dc = dc; v.data = d;
    v.xs = 16'(xs); v.xe = 16'(xe); v.ys = 16'(ys); v.ye = 16'(ye);
    v.npix = np;
    vq.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    spi_if.lcd_spi_mosi = b;
    spi_if.lcd_spi_sclk = 1'b0;
    wait_clk(4);
    spi_if.lcd_spi_sclk = 1'b1;
    rise_cyc = cyc;
    wait_clk(4);
    spi_if.lcd_spi_sclk = 1'b0;
  endtask

  task automatic send_byte(input logic dc, input logic [7:0] b);
    spi_if.lcd_spi_cs = 1'b0;
    spi_if.lcd_dc     = dc;
    wait_clk(2);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    wait_clk(6);
    exp_bytes++;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, " rx_valid"}, 32'(rx_valid), 32'd0);
    chk({tag, " rx_byte"}, 32'(rx_byte), 32'd0);
    chk({tag, " rx_dc"}, 32'(rx_dc), 32'd0);
    chk({tag, " byte_cnt"}, byte_cnt, 32'd0);
    chk({tag, " frame_err"}, 32'(frame_err), 32'd0);
    chk({tag, " x window"}, {x_start, x_end}, {16'd0, 16'd239});
    chk({tag, " y window"}, {y_start, y_end}, {16'd0, 16'd319});
    chk({tag, " pix"}, {15'd0, pix_valid, pix_data}, 32'd0);
    chk({tag, " pix xy"}, {pix_x, pix_y}, 32'd0);
  endtask

  int          base_pix;
  int          rx_before;
  logic [15:0] exp_px [5];
  logic [15:0] exp_py [5];
  logic [15:0] exp_pd [5];

  initial begin
    spi_if.lcd_spi_sclk = 1'b0;
    spi_if.lcd_spi_mosi = 1'b0;
    spi_if.lcd_spi_cs   = 1'b1;
    spi_if.lcd_dc       = 1'b0;
    spi_if.lcd_reset    = 1'b1;

    add_vec(0, 8'h2A,  0, 239, 0, 319, 0);
    add_vec(1, 8'h00,  0, 239, 0, 319, 0);
    add_vec(1, 8'h0A,  0, 239, 0, 319, 0);
    add_vec(1, 8'h00,  0, 239, 0, 319, 0);
    add_vec(1, 8'h0B, 10,  11, 0, 319, 0);
    add_vec(0, 8'h2B, 10,  11, 0, 319, 0);
    add_vec(1, 8'h00, 10,  11, 0, 319, 0);
    add_vec(1, 8'h05, 10,  11, 0, 319, 0);
    add_vec(1, 8'h00, 10,  11, 0, 319, 0);
    add_vec(1, 8'h06, 10,  11, 5,   6, 0);
    add_vec(0, 8'h2C, 10,  11, 5,   6, 0);
    add_vec(1, 8'hF8, 10,  11, 5,   6, 0);
    add_vec(1, 8'h00, 10,  11, 5,   6, 1);
    add_vec(1, 8'h07, 10,  11, 5,   6, 1);
    add_vec(1, 8'hE0, 10,  11, 5,   6, 2);
    add_vec(1, 8'h00, 10,  11, 5,   6, 2);
    add_vec(1, 8'h1F, 10,  11, 5,   6, 3);
    add_vec(1, 8'hFF, 10,  11, 5,   6, 3);
    add_vec(1, 8'hFF, 10,  11, 5,   6, 4);
    add_vec(1, 8'h12, 10,  11, 5,   6, 4);
    add_vec(1, 8'h34, 10,  11, 5,   6, 5);

    exp_px = '{16'd10, 16'd11, 16'd10, 16'd11, 16'd10};
    exp_py = '{16'd5, 16'd5, 16'd6, 16'd6, 16'd5};
    exp_pd = '{16'hF800, 16'h07E0, 16'h001F, 16'hFFFF, 16'h1234};

    // Reset state
    wait_clk(4);
    check_reset_outputs("reset");
    rst = 1'b0;
    wait_clk(4);

    // Single byte capture and latency
    send_byte(1'b0, 8'hA5);
    chk("capture count", 32'(rx_n), 32'd1);
    chk("capture byte", 32'(last_b), 32'hA5);
    chk("capture dc", 32'(last_dc), 32'd0);
    chk("capture byte_cnt", byte_cnt, 32'(exp_bytes));
    chk("capture latency", 32'(rx_cyc - rise_cyc), 32'd3);

    // Window set and pixel stream, one byte per table entry
    base_pix = pq_x.size();
    for (int i = 0; i < vq.size(); i++) begin
      send_byte(vq[i].dc, vq[i].data);
      wait_clk(2);
      chk($sformatf("vec%0d rx_byte", i), 32'(last_b), 32'(vq[i].data));
      chk($sformatf("vec%0d rx_dc", i), 32'(last_dc), 32'(vq[i].dc));
      chk($sformatf("vec%0d byte_cnt", i), byte_cnt, 32'(exp_bytes));
      chk($sformatf("vec%0d x window", i), {x_start, x_end}, {vq[i].xs, vq[i].xe});
      chk($sformatf("vec%0d y window", i), {y_start, y_end}, {vq[i].ys, vq[i].ye});
      chk($sformatf("vec%0d pix count", i), 32'(pq_x.size() - base_pix), 32'(vq[i].npix));
    end
    for (int i = 0; i < 5; i++) begin
      if (pq_x.size() > base_pix + i) begin
        chk($sformatf("pix%0d xy", i), {pq_x[base_pix+i], pq_y[base_pix+i]}, {exp_px[i], exp_py[i]});
        chk($sformatf("pix%0d data", i), 32'(pq_d[base_pix+i]), 32'(exp_pd[i]));
      end else begin
        chk($sformatf("pix%0d present", i), 32'(pq_x.size()), 32'(base_pix + i + 1));
      end
    end

    // Odd trailing byte dropped by next command; truncated CASET leaves window
    base_pix = pq_x.size();
    send_byte(1'b0, 8'h2C);
    send_byte(1'b1, 8'hAB);
    send_byte(1'b0, 8'h2A);
    send_byte(1'b1, 8'h00);
    send_byte(1'b1, 8'h01);
    wait_clk(4);
    chk("preempt pix count", 32'(pq_x.size() - base_pix), 32'd0);
    chk("preempt x window", {x_start, x_end}, {16'd10, 16'd11});
    chk("preempt y window", {y_start, y_end}, {16'd5, 16'd6});

    // cs rising after 3 bits
    rx_before = rx_n;
    spi_if.lcd_spi_cs = 1'b0;
    wait_clk(2);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    spi_if.lcd_spi_cs = 1'b1;
    wait_clk(10);
    chk("cs mid-byte frame_err", 32'(frame_err), 32'd1);
    chk("cs mid-byte no rx", 32'(rx_n - rx_before), 32'd0);

    // Panel reset restores window and parser, keeps counters
    spi_if.lcd_reset = 1'b0;
    wait_clk(4);
    spi_if.lcd_reset = 1'b1;
    wait_clk(4);
    chk("panel x window", {x_start, x_end}, {16'd0, 16'd239});
    chk("panel y window", {y_start, y_end}, {16'd0, 16'd319});
    chk("panel byte_cnt kept", byte_cnt, 32'(exp_bytes));
    chk("panel frame_err kept", 32'(frame_err), 32'd1);
    send_byte(1'b1, 8'h00);
    send_byte(1'b1, 8'h00);
    send_byte(1'b1, 8'h00);
    send_byte(1'b1, 8'h05);
    wait_clk(2);
    chk("panel idle x window", {x_start, x_end}, {16'd0, 16'd239});
    chk("panel idle y window", {y_start, y_end}, {16'd0, 16'd319});

    // Synchronous reset mid-byte, then a clean byte
    spi_if.lcd_spi_cs = 1'b0;
    spi_if.lcd_dc     = 1'b1;
    wait_clk(2);
    for (int i = 0; i < 4; i++) send_bit(i[0]);
    rst = 1'b1;
    wait_clk(1);
    check_reset_outputs("sync rst");
    rst = 1'b0;
    exp_bytes = 0;
    wait_clk(4);
    rx_before = rx_n;
    send_byte(1'b1, 8'h3C);
    chk("post rst count", 32'(rx_n - rx_before), 32'd1);
    chk("post rst byte", 32'(last_b), 32'h3C);
    chk("post rst dc", 32'(last_dc), 32'd1);
    chk("post rst byte_cnt", byte_cnt, 32'(exp_bytes));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
